// File: rtl/execute_muldiv_reg.sv
// EX/MEM pipeline register with iterative RV32M multiply/divide unit.
// Optional MULDIV_EARLY_OUT_EN: zero-operand mul and div-by-zero skip iterations.
module execute_muldiv_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ValidE,
  input  logic                  FlushE,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic [4:0]            RdE,
  input  logic [DATA_WIDTH-1:0] PCPlus4E,
  input  logic [DATA_WIDTH-1:0] ALUResultE,
  input  logic [DATA_WIDTH-1:0] WriteDataE,
  input  logic                  MulDivE,
  input  logic [2:0]            MulDivOpE,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  output logic                  StallE,
  output logic                  ValidM,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM,
  output logic [4:0]            RdM,
  output logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic [DATA_WIDTH-1:0] ALUResultM,
  output logic [DATA_WIDTH-1:0] WriteDataM
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            div0_q, div0_d;

  logic            accept, is_div, a_sgn, b_sgn;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_abs, b_abs;
  logic [W:0]      madd, dtry;
  logic [2*W-1:0]  mul_nx, div_nx, prod;
  logic [W-1:0]    quo, rem, md_res;

  assign accept = ValidE & MulDivE & ~FlushE;
  assign is_div = MulDivOpE[2];
  assign a_sgn  = (MulDivOpE == 3'd1) | (MulDivOpE == 3'd2)
                | (MulDivOpE == 3'd4) | (MulDivOpE == 3'd6);
  assign b_sgn  = (MulDivOpE == 3'd1) | (MulDivOpE == 3'd4)
                | (MulDivOpE == 3'd6);
  assign a_neg  = a_sgn & SrcAE[W-1];
  assign b_neg  = b_sgn & SrcBE[W-1];
  assign a_abs  = a_neg ? -SrcAE : SrcAE;
  assign b_abs  = b_neg ? -SrcBE : SrcBE;

  // acc holds {hi, lo}: product/multiplier for mul, remainder/quotient for div
  assign madd   = {1'b0, acc_q[2*W-1:W]}
                + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
  assign mul_nx = {madd, acc_q[W-1:1]};
  assign dtry   = acc_q[2*W-1:W-1] - {1'b0, b_q};
  assign div_nx = dtry[W] ? {acc_q[2*W-2:0], 1'b0}
                          : {dtry[W-1:0], acc_q[W-2:0], 1'b1};

  assign prod = negq_q ? -acc_q : acc_q;
  assign quo  = div0_q ? {W{1'b1}}
              : (negq_q ? -acc_q[W-1:0] : acc_q[W-1:0]);
  assign rem  = negr_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    case (op_q)
      3'd0:       md_res = prod[W-1:0];
      3'd4, 3'd5: md_res = quo;
      3'd6, 3'd7: md_res = rem;
      default:    md_res = prod[2*W-1:W];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    div0_d  = div0_q;
    StallE  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          StallE  = 1'b1;
          op_d    = MulDivOpE;
          cnt_d   = '0;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          div0_d  = is_div & (SrcBE == '0);
          b_d     = is_div ? b_abs : a_abs;
          acc_d   = {{W{1'b0}}, is_div ? a_abs : b_abs};
          state_d = S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
          if (is_div ? (SrcBE == '0)
                     : ((SrcAE == '0) | (SrcBE == '0))) begin
            acc_d   = is_div ? {a_abs, {W{1'b0}}} : '0;
            state_d = S_FIN;
          end
`endif
        end
      end
      S_RUN: begin
        if (FlushE) begin
          state_d = S_IDLE;
        end else begin
          StallE = 1'b1;
          acc_d  = op_q[2] ? div_nx : mul_nx;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(W-1)) state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
    end
  end

  logic load_e, fin;
  assign fin    = (state_q == S_FIN);
  assign load_e = ~FlushE & (fin
                | ((state_q == S_IDLE) & ValidE & ~MulDivE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      RdM        <= '0;
      PCPlus4M   <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
    end else if (load_e) begin
      ValidM     <= 1'b1;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RdM        <= RdE;
      PCPlus4M   <= PCPlus4E;
      ALUResultM <= fin ? md_res : ALUResultE;
      WriteDataM <= WriteDataE;
    end else begin
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      RdM        <= '0;
      PCPlus4M   <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
    end
  end

endmodule

// File: tb/tb_execute_muldiv_reg.sv
// Scoreboard bench for execute_muldiv_reg.
// Honors MULDIV_EARLY_OUT_EN for expected stall length and latency.
module tb_execute_muldiv_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ValidE = 0, FlushE = 0, RegWriteE = 0, MemWriteE = 0;
  logic [1:0]  ResultSrcE = 0;
  logic [4:0]  RdE = 0;
  logic [31:0] PCPlus4E = 0, ALUResultE = 0, WriteDataE = 0;
  logic        MulDivE = 0;
  logic [2:0]  MulDivOpE = 0;
  logic [31:0] SrcAE = 0, SrcBE = 0;
  logic        StallE, ValidM, RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M, ALUResultM, WriteDataM;

  execute_muldiv_reg #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .RdE(RdE), .PCPlus4E(PCPlus4E),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .MulDivE(MulDivE), .MulDivOpE(MulDivOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .StallE(StallE),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cmp_n = 0;
  int   bad_n = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  function automatic bit fast(input logic [2:0] op,
                              input logic [31:0] a, b);
    return EO && (op[2] ? (b == 0) : (a == 0 || b == 0));
  endfunction

  always @(negedge clk) begin
    if (rst_n && ValidM) begin
      cmp_n++;
      if (sb.size() == 0) begin
        bad_n++;
        $display("FAIL unexpected_m: got res=%h rd=%0d cyc=%0d, required no output",
                 ALUResultM, RdM, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (ALUResultM !== mon_e.res || RdM !== mon_e.rd ||
            RegWriteM !== 1'b1 || cyc != mon_e.cyc) begin
          bad_n++;
          $display("FAIL m_result: got res=%h rd=%0d rw=%b cyc=%0d, required res=%h rd=%0d rw=1 cyc=%0d",
                   ALUResultM, RdM, RegWriteM, cyc,
                   mon_e.res, mon_e.rd, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, req);
    cmp_n++;
    if (got !== req) begin
      bad_n++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  task automatic issue_alu(input logic [31:0] val, input logic [4:0] rd);
    @(negedge clk);
    ValidE = 1; MulDivE = 0; FlushE = 0; RegWriteE = 1;
    ALUResultE = val; RdE = rd;
    sb.push_back('{val, rd, cyc + 1});
  endtask

  task automatic idle();
    @(negedge clk);
    ValidE = 0; MulDivE = 0; FlushE = 0;
  endtask

  task automatic issue_md(input string nm, input logic [2:0] op,
                          input logic [31:0] a, b, exp,
                          input logic [4:0] rd);
    int n;
    int es;
    @(negedge clk);
    ValidE = 1; MulDivE = 1; FlushE = 0; RegWriteE = 1;
    MulDivOpE = op; SrcAE = a; SrcBE = b; RdE = rd;
    ALUResultE = 32'hDEAD_BEEF;
    es = fast(op, a, b) ? 1 : 33;
    sb.push_back('{exp, rd, cyc + es + 1});
    n = 0;
    forever begin
      #1;
      if (!StallE) break;
      n++;
      if (n >= 100) break;
      @(negedge clk);
    end
    check({nm, "_stall"}, n, es);
  endtask

  initial begin
    PCPlus4E = 32'h0000_0104; WriteDataE = 32'h0000_0055;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out", {ValidM, StallE, RdM, ALUResultM[24:0]}, 32'h0);
    rst_n = 1;

    @(negedge clk);
    ValidE = 1; MulDivE = 1; MulDivOpE = 3'd0; SrcAE = 3; SrcBE = 4;
    repeat (5) @(negedge clk);
    #1;
    check("run_stall", {31'h0, StallE}, 32'h1);
    ValidE = 0; MulDivE = 0; rst_n = 0;
    #1;
    check("midrun_reset", {ValidM, StallE, RdM, ALUResultM[24:0]}, 32'h0);
    @(negedge clk);
    rst_n = 1;

    issue_alu(32'h0000_1234, 5'd5);
    issue_md("mul",     3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd1);
    issue_md("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd2);
    issue_md("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'd3);
    issue_md("div0",    3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'd4);
    issue_md("rem0",    3'd6, 32'd5,         32'd0,         32'd5,         5'd6);
    issue_md("divovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd7);
    issue_md("removf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         5'd8);
    issue_md("divu",    3'd5, 32'd100,       32'd7,         32'd14,        5'd9);
    issue_md("remu",    3'd7, 32'd100,       32'd7,         32'd2,         5'd10);
    issue_md("divneg",  3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 5'd11);
    issue_md("remneg",  3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 5'd12);
    issue_md("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 5'd13);
    issue_md("mulzero", 3'd0, 32'h0000_1234, 32'd0,         32'd0,         5'd14);
    issue_alu(32'h0000_0777, 5'd15);
    idle();

    @(negedge clk);
    ValidE = 1; MulDivE = 1; MulDivOpE = 3'd0; SrcAE = 5; SrcBE = 6;
    repeat (11) @(negedge clk);
    FlushE = 1;
    @(negedge clk);
    FlushE = 0; ValidE = 0; MulDivE = 0;
    #1;
    check("flush_out", {30'h0, StallE, ValidM}, 32'h0);
    issue_alu(32'h0000_ABCD, 5'd9);
    idle();

    repeat (3) @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_reg.md
# execute_muldiv_reg

EX/MEM boundary block of the 5-stage RV32 pipeline. It registers execute-stage results into the M-stage signals consumed by the memory/writeback stage. It also contains an iterative RV32M multiply/divide unit that stalls the upstream stages while it runs, then inserts the mul/div result into the M-stage ALU-result path.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ValidE  in  1  E-stage holds a real instruction
- FlushE  in  1  kill the E-stage instruction, including an in-flight mul/div
- RegWriteE, MemWriteE  in  1 each  control from ID/EX
- ResultSrcE  in  2  result-mux select, passed through
- RdE  in  5  destination register
- PCPlus4E, ALUResultE, WriteDataE  in  DATA_WIDTH each  from PC adder, ALU and forwarded rs2
- MulDivE  in  1  instruction is RV32M
- MulDivOpE  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- SrcAE, SrcBE  in  DATA_WIDTH each  forwarded rs1/rs2 operands
- StallE  out  1  hold PC, IF/ID and ID/EX registers
- ValidM, RegWriteM, MemWriteM  out  1 each  M-stage control
- ResultSrcM  out  2
- RdM  out  5
- PCPlus4M, ALUResultM, WriteDataM  out  DATA_WIDTH each

## Operation
- All M outputs are registered. The downstream stage never stalls, so the M register loads every cycle.
- Non-mul/div, ValidE=1, FlushE=0: all E fields load into M; ValidM=1.
- Bubble: all M outputs are 0, including ValidM. A bubble loads when ValidE=0, when FlushE=1, or in any mul/div cycle other than FINISH.
- Mul/div FSM has three states: IDLE, RUN, FINISH.
- IDLE:
  - Accept condition: ValidE & MulDivE & ~FlushE.
  - On accept: latch operands (absolute values for the signed ops, plus the result sign), set count=0, go to RUN.
  - StallE=1 in the accept cycle.
- RUN:
  - One iteration per cycle: shift-add for multiply, restoring for divide.
  - count increments each cycle; at count==DATA_WIDTH-1, go to FINISH.
  - StallE=1 throughout.
- FINISH:
  - Sign correction is applied to the 2×DATA_WIDTH product or to the quotient/remainder.
  - The selected result drives the M register in place of ALUResultE, together with the held E control fields.
  - StallE=0; go to IDLE.
- Result selection:
  - MUL returns the low product half.
  - MULH, MULHSU and MULHU return the high product half, with rs1/rs2 signedness per funct3.
- Divide by zero: quotient = all ones; remainder = dividend.
- Signed overflow (0x80000000 / −1): quotient = 0x80000000; remainder = 0.
- FlushE in RUN or FINISH: go to IDLE, load a bubble, StallE=0, discard the result.
- StallE = (IDLE & accept) | RUN, computed combinationally.

## Timing
- Non-mul/div latency is 1 cycle, E to M.
- Mul/div with the instruction presented at cycle 0:
  - StallE is high for cycles 0..DATA_WIDTH (33 cycles).
  - FINISH is cycle DATA_WIDTH+1.
  - The result is visible on ALUResultM from cycle DATA_WIDTH+2 (34 cycles).
- A back-to-back mul/div is accepted in the cycle after FINISH, with no dead cycle beyond IDLE.
- Reset:
  - All M outputs are 0, state is IDLE, count is 0, StallE is 0.
  - Reset during RUN abandons the operation immediately.
- FlushE has priority over acceptance and over FINISH.

## Configuration
- MULDIV_EARLY_OUT_EN defined: in IDLE, an accepted op goes directly to FINISH, skipping RUN, if either multiply operand is 0 or the divisor is 0.
  - StallE is then high for 1 cycle; the result reaches M 2 cycles after presentation.
  - Results are identical to the full-length path.
- Undefined: every op takes the full DATA_WIDTH iterations.

## Test plan
- Reset and passthrough:
  - Assert rst_n=0 mid-RUN → M outputs 0, StallE=0, state IDLE.
  - Then ADD with ALUResultE=0x00001234, RdE=5 → next cycle ALUResultM=0x00001234, RdM=5, ValidM=1.
- MUL 7 × 0xFFFFFFFD (−3):
  - StallE high exactly 33 cycles.
  - Bubbles on M meanwhile.
  - ALUResultM=0xFFFFFFEB at cycle 34.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- Division corner cases:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
- Flush and restart:
  - FlushE at RUN count 10 → bubble, StallE low next cycle, no write.
  - The following ADD passes through with 1-cycle latency.
- With MULDIV_EARLY_OUT_EN defined, MUL x × 0 → StallE high 1 cycle, ALUResultM=0 two cycles after presentation.
